jtcps1_watch_log: RTL and testbench

JTCPS1_WATCH_LOG -- requirements
Module: jtcps1_watch_log

---
 rtl/jtcps1_watch_log.sv | 128 ++++++++++++
 tb/tb_jtcps1_watch_log.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/jtcps1_watch_log.sv
// Debug watch logger: counts rising edges per watch signal over each frame,
// snapshots the counts at the VB rise and exposes them through a byte-wide
// read port, plus a frame-stretched activity LED.

// One watch lane: edge detect, saturating live counter and frame snapshot.
module jtcps1_watch_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       bnd,
  input  logic       sig,
  output logic [7:0] snap,
  output logic       hit
);
  logic       sig_l;
  logic [7:0] cnt, cnt_nx;
  logic       ev;

  assign ev     = pxl_cen & sig & ~sig_l;
  assign cnt_nx = (ev && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
  // The snapshot about to be taken is nonzero: an edge on the boundary
  // cycle itself belongs to the frame being closed.
  assign hit    = cnt_nx != 8'd0;

  // Sample, count, and on a boundary move the count into the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_l <= 1'b0;
      cnt   <= 8'd0;
      snap  <= 8'd0;
    end else if (pxl_cen) begin
      sig_l <= sig;
      if (bnd) begin
        snap <= cnt_nx;
        cnt  <= 8'd0;
      end else begin
        cnt  <= cnt_nx;
      end
    end
  end
endmodule

module jtcps1_watch_log #(
  parameter int W     = 14,
  parameter int LEDFR = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pxl_cen,
  input  logic         VB,
  input  logic [W-1:0] sig_in,
  input  logic [7:0]   st_addr,
  output logic [7:0]   st_dout,
  output logic         led
);
  logic [15:0][7:0] snap;
  logic [15:0]      mask, hit;
  logic             vb_l, bnd;
  logic [7:0]       fcnt;
  logic [3:0]       lcnt, lcnt_nx;
  logic [7:0]       rd;

  assign bnd = pxl_cen & VB & ~vb_l;

  // Lanes above W are tied off so the read map sees zeros there.
  for (genvar i = 0; i < 16; i++) begin : g_lane
    if (i < W) begin : g_on
      jtcps1_watch_lane u_lane (
        .clk    (clk),
        .rst    (rst),
        .pxl_cen(pxl_cen),
        .bnd    (bnd),
        .sig    (sig_in[i]),
        .snap   (snap[i]),
        .hit    (hit[i])
      );
    end else begin : g_off
      assign snap[i] = 8'd0;
      assign hit[i]  = 1'b0;
    end
    assign mask[i] = snap[i] != 8'd0;
  end

  // LED hold counter: reload on an active frame, otherwise count down.
  always_comb begin
    lcnt_nx = lcnt;
    if (bnd) begin
      if (|hit)              lcnt_nx = 4'(LEDFR);
      else if (lcnt != 4'd0) lcnt_nx = lcnt - 4'd1;
    end
  end

  // Frame-level state: VB edge detect, frame counter, LED counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb_l <= 1'b0;
      fcnt <= 8'd0;
      lcnt <= 4'd0;
      led  <= 1'b0;
    end else begin
      lcnt <= lcnt_nx;
      led  <= lcnt_nx != 4'd0;
      if (pxl_cen) begin
        vb_l <= VB;
        if (bnd) fcnt <= fcnt + 8'd1;
      end
    end
  end

  // Read map decode.
  always_comb begin
    rd = 8'd0;
    case (st_addr) inside
      [8'h00:8'h0F]: rd = snap[st_addr[3:0]];
      8'h10:         rd = mask[7:0];
      8'h11:         rd = mask[15:8];
      8'h12:         rd = fcnt;
      8'h13:         rd = {7'd0, led};
      default:       rd = 8'd0;
    endcase
  end

  // Registered read data, updated every clk regardless of pxl_cen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_dout <= 8'd0;
    else     st_dout <= rd;
  end
endmodule

// File: tb/tb_jtcps1_watch_log.sv
// Directed bench for jtcps1_watch_log (W=14, LEDFR=8).
module tb_jtcps1_watch_log;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b0;
  logic        VB = 1'b0;
  logic [13:0] sig_in = '0;
  logic [7:0]  st_addr = '0;
  logic [7:0]  st_dout;
  logic        led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vt[10];

  jtcps1_watch_log #(.W(14), .LEDFR(8)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(VB),
    .sig_in(sig_in), .st_addr(st_addr), .st_dout(st_dout), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // One pxl_cen sample with the given inputs, then one idle clk.
  task automatic cen(input logic [13:0] s, input logic v);
    @(negedge clk); sig_in = s; VB = v; pxl_cen = 1'b1;
    @(negedge clk); pxl_cen = 1'b0;
  endtask

  task automatic pulse(input int b);
    cen(14'(1) << b, 1'b0);
    cen('0, 1'b0);
  endtask

  task automatic boundary();
    cen('0, 1'b1);
    cen('0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    @(negedge clk); st_addr = a; pxl_cen = 1'b0;
    @(posedge clk); #1;
    chk(name, st_dout, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; #1;
    chk("async_rst_dout", st_dout, 8'h00);
    chk("async_rst_led", {7'd0, led}, 8'h00);
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    vt[0] = '{8'h05, 8'h03, "snap5"};
    vt[1] = '{8'h10, 8'h20, "mask_lo"};
    vt[2] = '{8'h11, 8'h00, "mask_hi"};
    vt[3] = '{8'h12, 8'h01, "fcnt1"};
    vt[4] = '{8'h13, 8'h01, "led_rd"};
    vt[5] = '{8'h04, 8'h00, "snap4"};
    vt[6] = '{8'h06, 8'h00, "snap6"};
    vt[7] = '{8'h0E, 8'h00, "snap14_oob"};
    vt[8] = '{8'h0F, 8'h00, "snap15_oob"};
    vt[9] = '{8'h20, 8'h00, "unmapped"};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout", st_dout, 8'h00);
    chk("rst_led", {7'd0, led}, 8'h00);
    @(negedge clk); rst = 1'b0;
    rd(8'h12, 8'h00, "rst_fcnt");
    rd(8'h10, 8'h00, "rst_mask");

    // Three pulses on bit 5, then a boundary; read map table
    for (int k = 0; k < 3; k++) pulse(5);
    boundary();
    foreach (vt[k]) rd(vt[k].addr, vt[k].exp, vt[k].name);

    // Read latency is one clk: new address not visible before the edge
    @(negedge clk); st_addr = 8'h05; #1;
    chk("latency_hold", st_dout, 8'h00);
    @(posedge clk); #1;
    chk("latency_new", st_dout, 8'h03);

    // pxl_cen low: input activity is ignored
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); sig_in = 14'h3FFF; VB = k[0];
    end
    @(negedge clk); sig_in = '0; VB = 1'b0;
    rd(8'h12, 8'h01, "freeze_fcnt");
    rd(8'h05, 8'h03, "freeze_snap");
    boundary();
    rd(8'h03, 8'h00, "freeze_noev");
    rd(8'h05, 8'h00, "snap5_next");
    rd(8'h10, 8'h00, "mask_clear");

    // Saturation: 300 pulses on bit 0
    for (int k = 0; k < 300; k++) pulse(0);
    boundary();
    rd(8'h00, 8'hFF, "sat_snap0");
    rd(8'h10, 8'h01, "sat_mask");
    boundary();
    rd(8'h00, 8'h00, "sat_next");

    // Edge coincident with the VB rise counts in the closing frame
    cen(14'h2000, 1'b1);
    cen('0, 1'b0);
    rd(8'h0D, 8'h01, "coinc_snap13");
    rd(8'h11, 8'h20, "coinc_mask_hi");
    boundary();
    rd(8'h0D, 8'h00, "coinc_next");

    // Held-high signal counts once
    for (int k = 0; k < 3; k++) cen(14'h0002, 1'b0);
    cen(14'h0002, 1'b1);
    cen(14'h0002, 1'b0);
    rd(8'h01, 8'h01, "hold_first");
    cen(14'h0002, 1'b1);
    cen(14'h0002, 1'b0);
    rd(8'h01, 8'h00, "hold_second");
    cen('0, 1'b0);
    rd(8'h12, 8'h08, "fcnt8");

    // LED stretch after one active frame
    do_reset();
    rd(8'h12, 8'h00, "post_rst_fcnt");
    pulse(7);
    for (int b = 0; b <= 8; b++) begin
      boundary();
      rd(8'h13, (b < 8) ? 8'h01 : 8'h00, $sformatf("led_rd_b%0d", b));
      chk($sformatf("led_pin_b%0d", b), {7'd0, led}, (b < 8) ? 8'h01 : 8'h00);
    end
    rd(8'h12, 8'h09, "fcnt9");

    // Mid-frame reset discards live counts
    for (int k = 0; k < 4; k++) pulse(2);
    do_reset();
    pulse(2);
    boundary();
    rd(8'h02, 8'h01, "midrst_snap2");
    rd(8'h12, 8'h01, "midrst_fcnt");

    // Signal high at reset release counts once
    @(negedge clk); sig_in = 14'h0010;
    do_reset();
    for (int k = 0; k < 3; k++) cen(14'h0010, 1'b0);
    cen('0, 1'b0);
    boundary();
    rd(8'h04, 8'h01, "rel_high_snap4");

    // All signals active
    cen(14'h3FFF, 1'b0);
    cen('0, 1'b0);
    boundary();
    rd(8'h11, 8'h3F, "all_mask_hi");
    rd(8'h10, 8'hFF, "all_mask_lo");
    rd(8'h0D, 8'h01, "all_snap13");
    rd(8'h0E, 8'h00, "all_snap14_oob");
    rd(8'h13, 8'h01, "all_led");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
